adder_multi_word_sequencer: RTL and testbench
=============================================

# adder_multi_word_sequencer

Multi-cycle controller that performs a wide addition (NUM_WORDS × 32 bits) by sequencing one external 32-bit look-ahead-carry adder one word per cycle, least-significant word first. The carry is chained between words through an internal register. The block sits between a requesting datapath and the shared `Adder_with_Look_Ahead_Carry_Generator_32_Bit` instance. It drives that adder's enable, operands and carry-in, and captures its sum and carry-out.

## Interface
- NUM_WORDS, 4, number of 32-bit words per operand; legal range 2..16.
- Clock_In  in  1  system clock; all logic on the rising edge.
- Reset_In  in  1  synchronous, active-high reset.
- Start_In  in  1  request; sampled only in IDLE.
- Data_A_In  in  32*NUM_WORDS  operand A; captured on an accepted Start_In.
- Data_B_In  in  32*NUM_WORDS  operand B; captured on an accepted Start_In.
- Carry_In  in  1  initial carry into word 0; captured on an accepted Start_In.
- Busy_Out  out  1  high in RUN and DONE.
- Done_Out  out  1  one-cycle pulse when the result is valid.
- Sum_Out  out  32*NUM_WORDS  registered result; held until the next accepted start.
- Carry_Out  out  1  registered final carry; held with Sum_Out.
- Adder_Enable_Out  out  1  enable to the shared adder.
- Adder_Data_A_Out  out  32  current A word to the adder.
- Adder_Data_B_Out  out  32  current B word to the adder.
- Adder_Cin_Out  out  1  carry-in to the adder.
- Adder_Sum_In  in  32  adder sum (combinational path through the adder).
- Adder_Cout_In  in  1  adder carry-out.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - Adder_Enable_Out=0; adder operand outputs and Adder_Cin_Out driven 0.
  - Start_In=1 latches A, B and Carry_In into internal registers, clears word index to 0, clears Sum_Out and Carry_Out, then moves to RUN.
- RUN, each cycle:
  - Adder_Enable_Out=1.
  - Adder operands are word[idx] of the latched A and B.
  - Adder_Cin_Out is the latched Carry_In when idx=0, otherwise the chain-carry register.
  - At the clock edge, Adder_Sum_In is written to Sum_Out word idx and Adder_Cout_In is written to the chain-carry register.
  - If idx=NUM_WORDS-1: Carry_Out is also loaded from Adder_Cout_In, then the FSM moves to DONE. Otherwise idx increments.
- DONE: Done_Out=1 and Adder_Enable_Out=0 for exactly one cycle, then the FSM returns to IDLE.
- Start_In while Busy_Out=1 is ignored; it is not queued.
- Arithmetic: the result is modulo 2^(32·NUM_WORDS); Carry_Out is bit 32·NUM_WORDS of the true sum.
- Adder_Sum_In and Adder_Cout_In are sampled only while Adder_Enable_Out=1. The adder drives Z when disabled, so sampling at other times is forbidden.
- Reset, including mid-RUN:
  - FSM returns to IDLE and idx=0.
  - Sum_Out=0, Carry_Out=0, Done_Out=0, Busy_Out=0, Adder_* outputs all 0.
  - The partial result is discarded.

## Timing
- Start accepted at edge T0.
- RUN occupies cycles T0+1 .. T0+NUM_WORDS.
- Done_Out is high in cycle T0+NUM_WORDS+1; Sum_Out and Carry_Out are valid from that cycle onward.
- Total latency: NUM_WORDS+1 cycles from the start edge to Done_Out.
- Earliest next start: the cycle after DONE, i.e. a throughput of one operation per NUM_WORDS+2 cycles.
- Adder outputs are combinational. Adder operand registers change only at clock edges, so the external adder has one full cycle to settle.
- Sum_Out words update progressively during RUN. The full result is guaranteed only when Done_Out=1.

## Configuration
- Macro: ADDER_SEQ_SUBTRACT_EN.
- Defined:
  - Adds input port Subtract_In (1 bit), latched with the operands on an accepted start.
  - When latched high, every B word is bit-inverted before the adder, and the word-0 carry-in is forced to 1 (Carry_In is ignored). Result = A − B mod 2^(32·NUM_WORDS).
  - Carry_Out=1 means no borrow (A ≥ B unsigned).
- Undefined: port absent; addition only.

## Test plan
All scenarios use NUM_WORDS=4.
- A=all ones (128-bit), B=1, Carry_In=0 -> Sum_Out=0, Carry_Out=1, Done_Out high exactly 5 cycles after the start edge.
- A=0x0000_0000_0000_0000_0000_0000_FFFF_FFFF, B=0, Carry_In=1 -> Sum_Out=0x…0001_0000_0000; carry ripples into word 1 only; Carry_Out=0.
- Start_In held high during RUN with different operands -> second request ignored; result equals the first operation's; Adder_Enable_Out is high for exactly 4 cycles per operation.
- Reset_In asserted in the 2nd RUN cycle -> next cycle: IDLE, all outputs 0, no Done_Out pulse; a following start completes normally.
- With ADDER_SEQ_SUBTRACT_EN: A=5, B=7, Subtract_In=1 -> Sum_Out=2^128−2, Carry_Out=0. A=7, B=5 -> Sum_Out=2, Carry_Out=1.
- 20 random A, B and Carry_In values -> {Carry_Out, Sum_Out} equals the 129-bit reference sum; Passed/Failed/Total counts reported.

Source files
------------

// File: rtl/adder_multi_word_sequencer_if.sv
// Request/response and shared-adder signals of the multi-word adder sequencer.
// Subtract_In exists only when ADDER_SEQ_SUBTRACT_EN is defined.
interface adder_multi_word_sequencer_if #(
    parameter int NUM_WORDS = 4
);
    logic                     Start_In;
    logic [32*NUM_WORDS-1:0]  Data_A_In;
    logic [32*NUM_WORDS-1:0]  Data_B_In;
    logic                     Carry_In;
`ifdef ADDER_SEQ_SUBTRACT_EN
    logic                     Subtract_In;
`endif
    logic                     Busy_Out;
    logic                     Done_Out;
    logic [32*NUM_WORDS-1:0]  Sum_Out;
    logic                     Carry_Out;
    logic                     Adder_Enable_Out;
    logic [31:0]              Adder_Data_A_Out;
    logic [31:0]              Adder_Data_B_Out;
    logic                     Adder_Cin_Out;
    logic [31:0]              Adder_Sum_In;
    logic                     Adder_Cout_In;

    modport slave (
        input  Start_In, Data_A_In, Data_B_In, Carry_In,
`ifdef ADDER_SEQ_SUBTRACT_EN
        input  Subtract_In,
`endif
        output Busy_Out, Done_Out, Sum_Out, Carry_Out,
        output Adder_Enable_Out, Adder_Data_A_Out, Adder_Data_B_Out, Adder_Cin_Out,
        input  Adder_Sum_In, Adder_Cout_In
    );

    modport master (
        output Start_In, Data_A_In, Data_B_In, Carry_In,
`ifdef ADDER_SEQ_SUBTRACT_EN
        output Subtract_In,
`endif
        input  Busy_Out, Done_Out, Sum_Out, Carry_Out,
        input  Adder_Enable_Out, Adder_Data_A_Out, Adder_Data_B_Out, Adder_Cin_Out,
        output Adder_Sum_In, Adder_Cout_In
    );
endinterface

// File: rtl/adder_multi_word_sequencer.sv
// Wide adder built by sequencing one shared 32-bit adder, LSW first, carry chained internally.
// Optional A-B mode enabled by defining ADDER_SEQ_SUBTRACT_EN.
module adder_multi_word_sequencer #(
    parameter int NUM_WORDS = 4
) (
    input  logic                         Clock_In,
    input  logic                         Reset_In,
    adder_multi_word_sequencer_if.slave  bus
);
    localparam int W     = 32 * NUM_WORDS;
    localparam int IDX_W = $clog2(NUM_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               chain_q, chain_d;
    logic [W-1:0]       sum_q, sum_d;
    logic               cout_q, cout_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic               cin_q, cin_d;
    logic               sub_q, sub_d;

    logic               adder_en;
    logic [31:0]        adder_a;
    logic [31:0]        adder_b;
    logic               adder_cin;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        chain_d   = chain_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        a_d       = a_q;
        b_d       = b_q;
        cin_d     = cin_q;
        sub_d     = sub_q;
        adder_en  = 1'b0;
        adder_a   = '0;
        adder_b   = '0;
        adder_cin = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.Start_In) begin
                    a_d     = bus.Data_A_In;
                    b_d     = bus.Data_B_In;
                    cin_d   = bus.Carry_In;
`ifdef ADDER_SEQ_SUBTRACT_EN
                    sub_d   = bus.Subtract_In;
`else
                    sub_d   = 1'b0;
`endif
                    idx_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                adder_en = 1'b1;
                adder_a  = a_q[{idx_q, 5'b0} +: 32];
                // Subtraction is A + ~B + 1: invert B and force the word-0 carry.
                adder_b  = b_q[{idx_q, 5'b0} +: 32] ^ {32{sub_q}};
                if (idx_q == '0) begin
                    adder_cin = sub_q | cin_q;
                end else begin
                    adder_cin = chain_q;
                end
                sum_d[{idx_q, 5'b0} +: 32] = bus.Adder_Sum_In;
                chain_d = bus.Adder_Cout_In;
                if (idx_q == LAST_IDX) begin
                    cout_d  = bus.Adder_Cout_In;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock_In) begin
        if (Reset_In) begin
            state_q <= IDLE;
            idx_q   <= '0;
            chain_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            sub_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            chain_q <= chain_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            sub_q   <= sub_d;
        end
    end

    // Operand latches need no reset: they are only read in RUN, after a start loads them.
    always_ff @(posedge Clock_In) begin
        a_q   <= a_d;
        b_q   <= b_d;
        cin_q <= cin_d;
    end

    assign bus.Busy_Out         = (state_q != IDLE);
    assign bus.Done_Out         = (state_q == DONE);
    assign bus.Sum_Out          = sum_q;
    assign bus.Carry_Out        = cout_q;
    assign bus.Adder_Enable_Out = adder_en;
    assign bus.Adder_Data_A_Out = adder_a;
    assign bus.Adder_Data_B_Out = adder_b;
    assign bus.Adder_Cin_Out    = adder_cin;
endmodule

// File: tb/tb_adder_multi_word_sequencer.sv
// Directed and random bench for adder_multi_word_sequencer with NUM_WORDS=4 and a behavioural 32-bit adder.
module tb_adder_multi_word_sequencer;
    localparam int NW = 4;
    localparam int W  = 32 * NW;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    adder_multi_word_sequencer_if #(.NUM_WORDS(NW)) bus ();

    adder_multi_word_sequencer #(.NUM_WORDS(NW)) dut (
        .Clock_In (clk),
        .Reset_In (rst),
        .bus      (bus)
    );

    // Shared 32-bit adder; a junk pattern stands in for its high-Z output while disabled.
    logic [32:0] add_full;
    assign add_full = {1'b0, bus.Adder_Data_A_Out} + {1'b0, bus.Adder_Data_B_Out}
                    + {32'd0, bus.Adder_Cin_Out};
    assign bus.Adder_Sum_In  = bus.Adder_Enable_Out ? add_full[31:0] : 32'hDEAD_BEEF;
    assign bus.Adder_Cout_In = bus.Adder_Enable_Out ? add_full[32]   : 1'b1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required finish before 500000");
        $fatal(1, "watchdog");
    end

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input bit hold, output logic [W-1:0] sum, output logic cout,
                          output int lat, output int en_cnt, output bit timeout,
                          output logic done_after, output logic [W-1:0] sum_after);
        bus.Data_A_In = a;
        bus.Data_B_In = b;
        bus.Carry_In  = cin;
        bus.Start_In  = 1'b1;
        @(posedge clk); #1;
        if (hold) begin
            bus.Data_A_In = ~a;
            bus.Data_B_In = b ^ 128'h0123_4567_89AB_CDEF_0F0F_F0F0_5555_AAAA;
            bus.Carry_In  = ~cin;
        end else begin
            bus.Start_In = 1'b0;
        end
        lat     = 0;
        en_cnt  = 0;
        timeout = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            lat = n;
            if (bus.Adder_Enable_Out) en_cnt++;
            if (bus.Done_Out) begin
                timeout = 1'b0;
                break;
            end
            @(posedge clk); #1;
        end
        bus.Start_In = 1'b0;
        sum  = bus.Sum_Out;
        cout = bus.Carry_Out;
        @(posedge clk); #1;
        done_after = bus.Done_Out;
        sum_after  = bus.Sum_Out;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.Busy_Out, bus.Done_Out, bus.Carry_Out, bus.Adder_Enable_Out, bus.Adder_Cin_Out} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 00000",
                     {bus.Busy_Out, bus.Done_Out, bus.Carry_Out, bus.Adder_Enable_Out, bus.Adder_Cin_Out});
        end
        checks++;
        if (bus.Sum_Out !== '0) begin
            errors++;
            $display("FAIL reset_sum: got %h required 0", bus.Sum_Out);
        end
        checks++;
        if ({bus.Adder_Data_A_Out, bus.Adder_Data_B_Out} !== 64'd0) begin
            errors++;
            $display("FAIL reset_adder_ops: got %h required 0", {bus.Adder_Data_A_Out, bus.Adder_Data_B_Out});
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_carry_all_ones();
        logic [W-1:0] s, s2;
        logic c, d2;
        int lat, en;
        bit to;
        run_op({W{1'b1}}, 128'd1, 1'b0, 1'b0, s, c, lat, en, to, d2, s2);
        checks++;
        if (to) begin errors++; $display("FAIL ones_timeout: no Done_Out within 20 cycles"); end
        checks++;
        if (s !== 128'd0) begin errors++; $display("FAIL ones_sum: got %h required 0", s); end
        checks++;
        if (c !== 1'b1) begin errors++; $display("FAIL ones_cout: got %b required 1", c); end
        checks++;
        if (lat != 5) begin errors++; $display("FAIL ones_latency: got %0d required 5", lat); end
        checks++;
        if (en != 4) begin errors++; $display("FAIL ones_enable_cycles: got %0d required 4", en); end
        checks++;
        if (d2 !== 1'b0) begin errors++; $display("FAIL ones_done_width: got %b required 0", d2); end
        checks++;
        if (s2 !== 128'd0 || bus.Carry_Out !== 1'b1) begin
            errors++;
            $display("FAIL ones_hold: got %h/%b required 0/1", s2, bus.Carry_Out);
        end
    endtask

    task automatic test_ripple_word1();
        logic [W-1:0] s, s2;
        logic c, d2;
        int lat, en;
        bit to;
        run_op(128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF, 128'd0, 1'b1, 1'b0, s, c, lat, en, to, d2, s2);
        checks++;
        if (to || s !== 128'h0000_0000_0000_0000_0000_0001_0000_0000) begin
            errors++;
            $display("FAIL ripple_sum: got %h required 00000000000000000000000100000000", s);
        end
        checks++;
        if (c !== 1'b0) begin errors++; $display("FAIL ripple_cout: got %b required 0", c); end
    endtask

    task automatic test_start_ignored();
        logic [W-1:0] a, b, s, s2;
        logic c, d2;
        int lat, en;
        bit to;
        a = 128'h8000_0000_1234_5678_FFFF_FFFF_0000_0001;
        b = 128'h8000_0000_0000_0001_0000_0001_FFFF_FFFF;
        // a+b = 1_0000_0000_1234_567A_0000_0001_0000_0000 (129 bits)
        run_op(a, b, 1'b0, 1'b1, s, c, lat, en, to, d2, s2);
        checks++;
        if (to || s !== 128'h0000_0000_1234_567A_0000_0001_0000_0000) begin
            errors++;
            $display("FAIL hold_sum: got %h required 000000001234567a0000000100000000", s);
        end
        checks++;
        if (c !== 1'b1) begin errors++; $display("FAIL hold_cout: got %b required 1", c); end
        checks++;
        if (en != 4) begin errors++; $display("FAIL hold_enable_cycles: got %0d required 4", en); end
        checks++;
        if (bus.Busy_Out !== 1'b0) begin errors++; $display("FAIL hold_requeue: busy got %b required 0", bus.Busy_Out); end
    endtask

    task automatic test_reset_mid_run();
        logic [W-1:0] s, s2;
        logic c, d2;
        int lat, en;
        bit to, saw;
        bus.Data_A_In = {4{32'hFFFF_FFFF}};
        bus.Data_B_In = {4{32'h0000_0003}};
        bus.Carry_In  = 1'b1;
        bus.Start_In  = 1'b1;
        @(posedge clk); #1;
        bus.Start_In = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if ({bus.Busy_Out, bus.Done_Out, bus.Carry_Out, bus.Adder_Enable_Out, bus.Adder_Cin_Out} !== 5'b0 ||
            {bus.Adder_Data_A_Out, bus.Adder_Data_B_Out} !== 64'd0) begin
            errors++;
            $display("FAIL midreset_ctrl: got %b %h required 00000 0",
                     {bus.Busy_Out, bus.Done_Out, bus.Carry_Out, bus.Adder_Enable_Out, bus.Adder_Cin_Out},
                     {bus.Adder_Data_A_Out, bus.Adder_Data_B_Out});
        end
        checks++;
        if (bus.Sum_Out !== '0) begin errors++; $display("FAIL midreset_sum: got %h required 0", bus.Sum_Out); end
        saw = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (bus.Done_Out || bus.Busy_Out) saw = 1'b1;
            @(posedge clk); #1;
        end
        checks++;
        if (saw) begin errors++; $display("FAIL midreset_no_done: got activity 1 required 0"); end
        run_op(128'd100, 128'd23, 1'b0, 1'b0, s, c, lat, en, to, d2, s2);
        checks++;
        if (to || s !== 128'd123 || c !== 1'b0) begin
            errors++;
            $display("FAIL midreset_after: got %h/%b required 7b/0", s, c);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, s, s2;
        logic [W:0] ref_sum;
        logic c, cin, d2;
        int lat, en, passed, failed;
        bit to;
        passed = 0;
        failed = 0;
        for (int i = 0; i < 20; i++) begin
            a   = {$urandom(), $urandom(), $urandom(), $urandom()};
            b   = {$urandom(), $urandom(), $urandom(), $urandom()};
            if (i == 0) b = ~a;
            cin = 1'($urandom_range(0, 1));
            ref_sum = {1'b0, a} + {1'b0, b} + {128'd0, cin};
            run_op(a, b, cin, 1'b0, s, c, lat, en, to, d2, s2);
            checks++;
            if (to || {c, s} !== ref_sum) begin
                errors++;
                failed++;
                $display("FAIL random_%0d: got %h required %h", i, {c, s}, ref_sum);
            end else begin
                passed++;
            end
        end
        $display("random: passed %0d failed %0d total %0d", passed, failed, passed + failed);
    endtask

`ifdef ADDER_SEQ_SUBTRACT_EN
    task automatic test_subtract();
        logic [W-1:0] s, s2;
        logic c, d2;
        int lat, en;
        bit to;
        bus.Subtract_In = 1'b1;
        run_op(128'd5, 128'd7, 1'b0, 1'b0, s, c, lat, en, to, d2, s2);
        checks++;
        if (to || s !== {{127{1'b1}}, 1'b0} || c !== 1'b0) begin
            errors++;
            $display("FAIL sub_5_7: got %h/%b required fffffffffffffffffffffffffffffffe/0", s, c);
        end
        run_op(128'd7, 128'd5, 1'b0, 1'b0, s, c, lat, en, to, d2, s2);
        checks++;
        if (to || s !== 128'd2 || c !== 1'b1) begin
            errors++;
            $display("FAIL sub_7_5: got %h/%b required 2/1", s, c);
        end
        bus.Subtract_In = 1'b0;
    endtask
`endif

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        bus.Start_In  = 1'b0;
        bus.Data_A_In = '0;
        bus.Data_B_In = '0;
        bus.Carry_In  = 1'b0;
`ifdef ADDER_SEQ_SUBTRACT_EN
        bus.Subtract_In = 1'b0;
`endif
        @(posedge clk); #1;
        test_reset();
        test_carry_all_ones();
        test_ripple_word1();
        test_start_ignored();
        test_reset_mid_run();
`ifdef ADDER_SEQ_SUBTRACT_EN
        test_subtract();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
